// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// State enum, PC width, NOP word and reset PC.
package fetch_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int PC_WIDTH = ADDR_W + 2;
  localparam int CNT_W    = 16;

  localparam int unsigned RESET_PC = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready holding register between fetch and decode.
// Ports: clk, rst, flush, load, ready, next_data/next_pc in; valid, data, pc out.
module fetch_out_reg
  import fetch_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int PW = PC_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          load,
  input  logic          ready,
  input  logic [DW-1:0] next_data,
  input  logic [PW-1:0] next_pc,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic [PW-1:0] pc
);

  // Flush beats load; a transfer with no refill empties the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= next_data;
      pc    <= next_pc;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, ROM address, output handshake, redirect.
// Ports: clk, rst, run, rom_*, redirect_*, instr_*, misalign_err, retired_cnt.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int          DATA_WIDTH = DATA_W,
  parameter int          ADDR_WIDTH = ADDR_W,
  parameter int unsigned RESET_PC   = fetch_pkg::RESET_PC,
  parameter int          CNT_WIDTH  = CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH+1:0] redirect_pc,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH+1:0] instr_pc,
  input  logic                  instr_ready,
  output logic                  misalign_err,
  output logic [CNT_WIDTH-1:0]  retired_cnt
);

  localparam int PCW = ADDR_WIDTH + 2;
  localparam logic [PCW-1:0] PC_INIT = PCW'(RESET_PC);

  fetch_state_e   state;
  fetch_state_e   state_next;
  logic           fetching;
  logic           load;
  logic           xfer;
  logic [PCW-1:0] pc;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (run)  state_next = RUN;
      RUN:  if (!run) state_next = IDLE;
    endcase
  end

  always_comb begin
    fetching = (state == RUN);
  end

  assign xfer = instr_valid && instr_ready;
  assign load = fetching && !redirect_valid
             && (!instr_valid || instr_ready);

  // Redirect drops the byte offset; pc wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)
      pc <= PC_INIT;
    else if (redirect_valid)
      pc <= {redirect_pc[PCW-1:2], 2'b00};
    else if (load)
      pc <= pc + PCW'(4);
  end

  assign rom_addr = pc[PCW-1:2];

  always_ff @(posedge clk) begin
    if (rst)
      misalign_err <= 1'b0;
    else if (redirect_valid && |redirect_pc[1:0])
      misalign_err <= 1'b1;
  end

  // A transfer alongside a redirect still retires.
  always_ff @(posedge clk) begin
    if (rst)       retired_cnt <= '0;
    else if (xfer) retired_cnt <= retired_cnt + 1'b1;
  end

  fetch_out_reg #(
    .DW (DATA_WIDTH),
    .PW (PCW)
  ) u_out (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .load      (load),
    .ready     (instr_ready),
    .next_data (rom_data),
    .next_pc   (pc),
    .valid     (instr_valid),
    .data      (instr_data),
    .pc        (instr_pc)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch with a 16-word ROM and a reference model.
// Directed vectors plus per-cycle model comparison.
module tb_instr_fetch;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [3:0]  rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid = 1'b0;
  logic [5:0]  redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [5:0]  instr_pc;
  logic        instr_ready = 1'b0;
  logic        misalign_err;
  logic [15:0] retired_cnt;

  int checks = 0;
  int failures = 0;

  logic [31:0] rom [16];

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .run            (run),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .misalign_err   (misalign_err),
    .retired_cnt    (retired_cnt)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: transaction-level view of fetch.
  bit        m_ok = 0;
  int        m_pc;
  bit        m_run;
  bit        m_vld;
  int        m_data;
  int        m_ipc;
  bit        m_err;
  int        m_cnt;
  bit        m_take;

  always @(posedge clk) begin
    if (rst) begin
      m_ok   = 1;
      m_pc   = 0;
      m_run  = 0;
      m_vld  = 0;
      m_data = 0;
      m_ipc  = 0;
      m_err  = 0;
      m_cnt  = 0;
    end else if (m_ok) begin
      m_take = m_vld && instr_ready;
      if (m_take) m_cnt = (m_cnt + 1) % 65536;
      if (redirect_valid) begin
        if (redirect_pc % 4 != 0) m_err = 1;
        m_pc  = redirect_pc - (redirect_pc % 4);
        m_vld = 0;
      end else if (m_run && (!m_vld || instr_ready)) begin
        m_data = rom[m_pc / 4];
        m_ipc  = m_pc;
        m_vld  = 1;
        m_pc   = (m_pc + 4) % 64;
      end else if (m_take) begin
        m_vld = 0;
      end
      m_run = run;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_valid", {31'd0, instr_valid}, {31'd0, m_vld});
      if (m_vld) begin
        chk("m_data", instr_data, m_data);
        chk("m_pc", {26'd0, instr_pc}, m_ipc);
      end
      chk("m_rom_addr", {28'd0, rom_addr}, (m_pc / 4) % 16);
      chk("m_err", {31'd0, misalign_err}, {31'd0, m_err});
      chk("m_cnt", {16'd0, retired_cnt}, m_cnt);
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rom[0] = NOP;
    for (int k = 1; k < 16; k++)
      rom[k] = 32'h0001_01B3 + 32'(k - 1) * 32'h0000_8080;

    // Reset then stream
    cyc();
    cyc();
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_cnt", {16'd0, retired_cnt}, 32'd0);
    chk("rst_err", {31'd0, misalign_err}, 32'd0);
    chk("rst_addr", {28'd0, rom_addr}, 32'd0);
    rst = 1'b0;
    run = 1'b1;
    instr_ready = 1'b1;
    cyc();
    chk("lat_valid", {31'd0, instr_valid}, 32'd0);
    cyc();
    chk("first_valid", {31'd0, instr_valid}, 32'd1);
    chk("first_data", instr_data, 32'h0000_0013);
    chk("first_pc", {26'd0, instr_pc}, 32'h00);
    cyc();
    chk("second_data", instr_data, 32'h0001_01B3);
    chk("second_pc", {26'd0, instr_pc}, 32'h04);
    cyc();
    chk("third_data", instr_data, 32'h0001_8233);
    chk("third_pc", {26'd0, instr_pc}, 32'h08);
    chk("cnt_two", {16'd0, retired_cnt}, 32'd2);

    // Backpressure
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_data", instr_data, 32'h0001_8233);
      chk("bp_pc", {26'd0, instr_pc}, 32'h08);
      chk("bp_cnt", {16'd0, retired_cnt}, 32'd2);
    end
    instr_ready = 1'b1;
    cyc();
    chk("bp_next_data", instr_data, 32'h0002_02B3);
    chk("bp_next_pc", {26'd0, instr_pc}, 32'h0C);
    chk("bp_next_cnt", {16'd0, retired_cnt}, 32'd3);

    // Wrap-around
    repeat (12) cyc();
    chk("w16_data", instr_data, 32'h0008_08B3);
    chk("w16_pc", {26'd0, instr_pc}, 32'h3C);
    cyc();
    chk("w17_data", instr_data, 32'h0000_0013);
    chk("w17_pc", {26'd0, instr_pc}, 32'h00);
    chk("w17_cnt", {16'd0, retired_cnt}, 32'd16);

    // Redirect coincident with a transfer
    redirect_valid = 1'b1;
    redirect_pc = 6'h20;
    cyc();
    redirect_valid = 1'b0;
    chk("rd_bubble", {31'd0, instr_valid}, 32'd0);
    chk("rd_cnt", {16'd0, retired_cnt}, 32'd17);
    cyc();
    chk("rd_valid", {31'd0, instr_valid}, 32'd1);
    chk("rd_data", instr_data, 32'h0004_8533);
    chk("rd_pc", {26'd0, instr_pc}, 32'h20);
    cyc();
    chk("rd_next_pc", {26'd0, instr_pc}, 32'h24);

    // Misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc = 6'h22;
    cyc();
    redirect_valid = 1'b0;
    chk("mis_err", {31'd0, misalign_err}, 32'd1);
    chk("mis_bubble", {31'd0, instr_valid}, 32'd0);
    chk("mis_cnt", {16'd0, retired_cnt}, 32'd19);
    cyc();
    chk("mis_data", instr_data, 32'h0004_8533);
    chk("mis_pc", {26'd0, instr_pc}, 32'h20);
    cyc();
    chk("mis_sticky", {31'd0, misalign_err}, 32'd1);

    // run=0 with a held instruction
    run = 1'b0;
    instr_ready = 1'b0;
    repeat (2) begin
      cyc();
      chk("hold_valid", {31'd0, instr_valid}, 32'd1);
      chk("hold_data", instr_data, 32'h0005_05B3);
      chk("hold_pc", {26'd0, instr_pc}, 32'h24);
    end
    instr_ready = 1'b1;
    repeat (2) begin
      cyc();
      chk("stop_valid", {31'd0, instr_valid}, 32'd0);
      chk("stop_cnt", {16'd0, retired_cnt}, 32'd21);
    end

    // Reset mid-stream, overriding a redirect
    run = 1'b1;
    repeat (3) cyc();
    instr_ready = 1'b0;
    cyc();
    chk("pre_rst_valid", {31'd0, instr_valid}, 32'd1);
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 6'h2A;
    cyc();
    chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("mid_rst_cnt", {16'd0, retired_cnt}, 32'd0);
    chk("mid_rst_err", {31'd0, misalign_err}, 32'd0);
    chk("mid_rst_addr", {28'd0, rom_addr}, 32'd0);
    rst = 1'b0;
    redirect_valid = 1'b0;
    run = 1'b0;
    repeat (2) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
